ahb_ssram_ctrl: RTL and testbench
=================================

# ahb_ssram_ctrl

AHB-Lite slave front end for the single-port synchronous write-first RAM in the AHB-to-SSRAM path. It converts AHB address/data phases into RAM enable/write/address/data strobes with zero wait states for word reads and writes. A one-entry posted write buffer with read forwarding resolves the port conflict between a write data phase and a following read address phase. Sub-word writes are optionally handled by read-modify-write.

## Interface
- ADDR_WIDTH, 10: RAM word-address width; the RAM holds 2^ADDR_WIDTH 32-bit words.
- HCLK  in  1  system clock; every register is rising-edge.
- HRESETn  in  1  asynchronous active-low reset; one clock, asynchronous active-low reset, as decided.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; word index = HADDR[ADDR_WIDTH+1:2]; upper bits ignored.
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; larger sizes are illegal.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus ready.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM word address.
- ram_di  out  32  RAM write data.
- ram_dout  in  32  RAM read data; registered, valid one cycle after ram_en with ram_we = 0.

## Operation
- A transfer is accepted when HSEL & HTRANS[1] & HREADY. Address, write flag and byte mask are captured for the data phase.
- Byte mask is little-endian. Byte: 1<<HADDR[1:0]. Half: 2'b11<<{HADDR[1],1'b0}. Word: 4'hF.
- A halfword at HADDR[0] = 1 or HSIZE > 2 gives ERROR. No write occurs.
- Write buffer registers: buf_valid, buf_addr, buf_data, buf_mask.
- RAM port priority per cycle:
  - (1) RMW sequence;
  - (2) accepted read address phase: ram_en = 1, ram_we = 0, ram_addr = HADDR word;
  - (3) drain: buf_valid with full mask gives ram_en = ram_we = 1, ram_addr = buf_addr, ram_di = buf_data, and buf_valid clears.
- A word-write data phase loads the buffer from HWDATA with mask F and sets buf_valid.
- A write address phase never uses the port. Any pending buffer therefore drains no later than the address phase of the next write, so the buffer is always empty when new write data arrives.
- Read data phase: if buf_valid and buf_addr equals the read address, HRDATA = buf_data. Otherwise HRDATA = ram_dout. The comparison uses the buffer state during the data phase.
- FSM states:
  - IDLE: OKAY, HREADYOUT = 1.
  - RMW_RD (sub-word write data phase, first cycle): RAM read of the write address, HREADYOUT = 0.
  - RMW_MRG: buffer loads (ram_dout & ~mask) | (HWDATA & mask) with full mask, HREADYOUT = 1, then back to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1.
  - ERR2: HREADYOUT = 1, HRESP = 1, then IDLE.
- IDLE/BUSY transfers and unselected transfers: OKAY, zero wait.
- Reset: HREADYOUT = 1, HRESP = 0, buf_valid = 0, FSM = IDLE, ram_en = ram_we = 0, HRDATA = 0. A pending buffered write is discarded. A reset mid-RMW aborts with no RAM write.

## Timing
- Word read: 0 wait states. RAM is read in the address-phase cycle; data is returned in the data phase.
- Word write: 0 wait states on the bus. The RAM write is posted and drains in the first cycle with no read address phase.
- Sub-word write (RMW enabled): 1 wait state.
- ERROR: 2 cycles.
- Back-to-back reads with a buffered write pending: the buffer is held indefinitely and forwarding stays correct.

## Configuration
- AHB_SSRAM_RMW_EN defined: sub-word writes use RMW_RD/RMW_MRG.
- AHB_SSRAM_RMW_EN undefined: sub-word writes get an ERROR response. The RMW states and merge logic are absent, and buf_mask is always F.

## Structure
- Package ahb_ssram_pkg holds:
  - HTRANS and HSIZE encodings;
  - the FSM state enum;
  - the byte-mask function;
  - the 32-bit data width constant.
- Sub-module ahb_ssram_wbuf holds the buffer registers, drain request and forwarding mux.

## Test plan
- Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> the read returns 0xDEADBEEF via forwarding with 0 wait states; the drain reaches RAM later.
- Write A = 0x11111111 at 0x0, read 0x4 ×5, then IDLE -> the reads return RAM data; the write drains in the IDLE cycle (ram_we = 1, ram_addr = 0).
- With RMW enabled and RAM[0x8] = 0xAABBCCDD, byte write 0x55 at 0x9 -> 1 wait state; a subsequent read of 0x8 returns 0xAABB55DD.
- With RMW disabled, halfword write at 0x2 -> ERROR in 2 cycles (HREADYOUT 0 then 1, HRESP = 1 both cycles); RAM is unchanged.
- HSIZE = 3 read -> ERROR; ram_en is not asserted in the address phase.
- Assert HRESETn low with a buffered write pending -> outputs take their reset values; after release, a read of that address returns the old RAM content.

Source files
------------

// File: rtl/ahb_ssram_pkg.sv
// Shared definitions for the AHB-Lite to synchronous SRAM controller:
// bus encodings, controller states, the data width and the byte-lane mask helper.
package ahb_ssram_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RMW_RD  = 3'd1,
    ST_RMW_MRG = 3'd2,
    ST_ERR1    = 3'd3,
    ST_ERR2    = 3'd4
  } state_e;

  // Little-endian byte lanes touched by a transfer of the given size.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = 4'b0011 << {addr_lo[1], 1'b0};
      default:    m = 4'hF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_ssram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the SSRAM controller.
interface ahb_ssram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_ssram_wbuf.sv
// One-entry posted write buffer: holds a write that lost the RAM port to a
// read, drains it when the port is free, and forwards it to reads that hit.
module ahb_ssram_wbuf
  import ahb_ssram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data,
  input  logic [3:0]            load_mask,
  input  logic                  port_busy,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic                  drain,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [DATA_W-1:0]     buf_data,
  output logic [DATA_W-1:0]     fwd_data
);

  logic       buf_valid;
  logic [3:0] buf_mask;

  // A full-word entry is written back whenever nobody else owns the port.
  assign drain = buf_valid & (&buf_mask) & ~port_busy;

  // Read hits on the pending entry return the buffered word, not stale RAM.
  assign fwd_data = (buf_valid && (buf_addr == fwd_addr)) ? buf_data : ram_dout;

  // Entry valid flag: set on load, cleared once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // Entry payload, captured on load only.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_addr <= load_addr;
      buf_data <= load_data;
      buf_mask <= load_mask;
    end
  end

endmodule

// File: rtl/ahb_ssram_ctrl.sv
// AHB-Lite slave front end for a single-port write-first synchronous RAM.
// Word reads/writes run with zero wait states; a write whose data phase
// collides with a read address phase is parked in ahb_ssram_wbuf.
// Build option: define AHB_SSRAM_RMW_EN to service byte/halfword writes by
// read-modify-write (one wait state); otherwise they get an ERROR response.
module ahb_ssram_ctrl
  import ahb_ssram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_ssram_ctrl_if.slave       bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_di,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam logic [3:0] FULL_MASK = 4'hF;

  state_e                  state, state_nxt;
  logic                    accept, illegal, rd_acc;
  logic                    vld_p1, write_p1;
  logic [ADDR_WIDTH-1:0]   addr_p1;
  logic [ADDR_WIDTH-1:0]   rd_word;
  logic                    wr_word, rmw_rd, rmw_mrg;
  logic                    port_busy, buf_load, drain;
  logic [DATA_W-1:0]       load_data, buf_data, fwd_data;
  logic [ADDR_WIDTH-1:0]   buf_addr;
  logic                    unused_bits;

  assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

  assign accept  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  assign rd_word = bus.HADDR[ADDR_WIDTH+1:2];

`ifdef AHB_SSRAM_RMW_EN
  logic              sub_acc;
  logic [3:0]        mask_p1;
  logic [DATA_W-1:0] merged;

  // Replace only the byte lanes being written.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [3:0]        mask);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

  assign sub_acc   = accept & ~illegal & bus.HWRITE & (bus.HSIZE != HSIZE_WORD);
  assign rmw_rd    = (state == ST_RMW_RD);
  assign rmw_mrg   = (state == ST_RMW_MRG);
  assign merged    = merge_bytes(ram_dout, bus.HWDATA, mask_p1);
  assign load_data = rmw_mrg ? merged : bus.HWDATA;

  // Byte lanes of the pending sub-word write.
  always_ff @(posedge HCLK) begin
    if (bus.HREADY) begin
      mask_p1 <= byte_mask(bus.HSIZE, bus.HADDR[1:0]);
    end
  end
`else
  assign rmw_rd    = 1'b0;
  assign rmw_mrg   = 1'b0;
  assign load_data = bus.HWDATA;
`endif

  // Illegal sizes and misaligned halfwords are refused before touching the RAM.
  always_comb begin
    illegal = (bus.HSIZE > HSIZE_WORD) ||
              ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0]);
`ifndef AHB_SSRAM_RMW_EN
    if (bus.HWRITE && (bus.HSIZE != HSIZE_WORD)) illegal = 1'b1;
`endif
  end

  assign rd_acc = accept & ~illegal & ~bus.HWRITE;

  // Address phase -> data phase: remember what the bus committed to.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_p1 <= 1'b0;
    end else if (bus.HREADY) begin
      vld_p1 <= accept & ~illegal;
    end
  end

  // Data-phase address and direction, captured with the transfer.
  always_ff @(posedge HCLK) begin
    if (bus.HREADY) begin
      write_p1 <= bus.HWRITE;
      addr_p1  <= rd_word;
    end
  end

  // A word write completes in its (single) data phase cycle.
  assign wr_word = vld_p1 & write_p1 & (state == ST_IDLE);

  // Next-state logic: error and RMW sequences are entered on acceptance.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_ERR1:    state_nxt = ST_ERR2;
`ifdef AHB_SSRAM_RMW_EN
      ST_RMW_RD:  state_nxt = ST_RMW_MRG;
`endif
      default: begin
        if (accept && illegal) state_nxt = ST_ERR1;
`ifdef AHB_SSRAM_RMW_EN
        else if (sub_acc)      state_nxt = ST_RMW_RD;
`endif
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Write data that cannot reach the RAM this cycle (a read owns the port)
  // is parked; otherwise it is written straight through.
  assign port_busy = rmw_rd | rd_acc | wr_word | rmw_mrg;
  assign buf_load  = (wr_word | rmw_mrg) & rd_acc;

  ahb_ssram_wbuf #(.ADDR_WIDTH(ADDR_WIDTH)) u_wbuf (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .load      (buf_load),
    .load_addr (addr_p1),
    .load_data (load_data),
    .load_mask (FULL_MASK),
    .port_busy (port_busy),
    .fwd_addr  (addr_p1),
    .ram_dout  (ram_dout),
    .drain     (drain),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .fwd_data  (fwd_data)
  );

  // RAM port arbitration: RMW read, then read address phase, then direct write, then drain.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = rd_word;
    ram_di   = buf_data;
    if (rmw_rd) begin
      ram_en   = 1'b1;
      ram_addr = addr_p1;
    end else if (rd_acc) begin
      ram_en   = 1'b1;
      ram_addr = rd_word;
    end else if (wr_word || rmw_mrg) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = addr_p1;
      ram_di   = load_data;
    end else if (drain) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = buf_addr;
      ram_di   = buf_data;
    end
  end

  assign bus.HRDATA    = (vld_p1 && !write_p1) ? fwd_data : '0;
  assign bus.HREADYOUT = ~((state == ST_RMW_RD) || (state == ST_ERR1));
  assign bus.HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

endmodule

// File: tb/tb_ahb_ssram_ctrl.sv
// Directed self-checking bench for ahb_ssram_ctrl with a write-first RAM model.
module tb_ahb_ssram_ctrl;
  import ahb_ssram_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di, ram_dout;
  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  ahb_ssram_ctrl_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_ssram_ctrl #(.ADDR_WIDTH(10)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_dout (ram_dout)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single-port synchronous write-first RAM.
  always @(posedge HCLK) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_di;
        ram_dout      <= ram_di;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = addr;
  endtask

  task automatic idle();
    drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn    = 1'b0;
    bus.HWDATA = 32'h0;
    idle();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[1] = 32'h44444444;
    mem[2] = 32'hAABBCCDD;
    mem[3] = 32'h33333333;

    // Reset state
    next_cycle(); next_cycle(); #2;
    check("rst_hreadyout", bus.HREADYOUT, 1);
    check("rst_hresp",     bus.HRESP,     0);
    check("rst_ram_en",    ram_en,        0);
    check("rst_ram_we",    ram_we,        0);
    check("rst_hrdata",    bus.HRDATA,    0);
    next_cycle(); HRESETn = 1'b1;

    // Write then back-to-back read of the same word: forwarded from buffer
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10); #2;
    check("t1_waddr_no_port", ram_en, 0);
    next_cycle(); bus.HWDATA = 32'hDEADBEEF; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10); #2;
    check("t1_rd_en",    ram_en,   1);
    check("t1_rd_we",    ram_we,   0);
    check("t1_rd_addr",  ram_addr, 4);
    next_cycle(); idle(); #2;
    check("t1_fwd_data", bus.HRDATA,    32'hDEADBEEF);
    check("t1_fwd_rdy",  bus.HREADYOUT, 1);
    check("t1_drain_we", ram_we,   1);
    check("t1_drain_ad", ram_addr, 4);
    check("t1_drain_di", ram_di,   32'hDEADBEEF);
    next_cycle(); #2;
    check("t1_mem",      mem[4],   32'hDEADBEEF);
    check("t1_idle_en",  ram_en,   0);

    // Write 0x0 then five reads of 0x4: buffer held until the idle cycle
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h0);
    next_cycle(); bus.HWDATA = 32'h11111111; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4); #2;
    check("t2_rd_addr",  ram_addr, 1);
    check("t2_rd_we",    ram_we,   0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); drive(1, HTRANS_SEQ, 0, HSIZE_WORD, 32'h4); #2;
      check("t2_rd_data", bus.HRDATA, 32'h44444444);
      check("t2_held_we", ram_we,     0);
    end
    next_cycle(); idle(); #2;
    check("t2_last_data", bus.HRDATA, 32'h44444444);
    check("t2_drain_we",  ram_we,     1);
    check("t2_drain_ad",  ram_addr,   0);
    check("t2_drain_di",  ram_di,     32'h11111111);

    // BUSY transfer: no RAM access, OKAY, no data
    next_cycle(); drive(1, HTRANS_BUSY, 0, HSIZE_WORD, 32'h4); #2;
    check("busy_en",  ram_en, 0);
    check("busy_rdy", bus.HREADYOUT, 1);
    next_cycle(); idle(); #2;
    check("busy_resp", bus.HRESP,  0);
    check("busy_data", bus.HRDATA, 0);

`ifdef AHB_SSRAM_RMW_EN
    // Byte write 0x55 at 0x9 merged into 0xAABBCCDD
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h9); #2;
    check("rmw_waddr_en", ram_en, 0);
    next_cycle(); bus.HWDATA = 32'h00005500; idle(); #2;
    check("rmw_rd_rdy",  bus.HREADYOUT, 0);
    check("rmw_rd_en",   ram_en,   1);
    check("rmw_rd_we",   ram_we,   0);
    check("rmw_rd_addr", ram_addr, 2);
    next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h8); #2;
    check("rmw_mrg_rdy", bus.HREADYOUT, 1);
    check("rmw_mrg_rd",  ram_addr, 2);
    next_cycle(); idle(); #2;
    check("rmw_rd_data", bus.HRDATA, 32'hAABB55DD);
    check("rmw_drain_di", ram_di,    32'hAABB55DD);
    check("rmw_drain_we", ram_we,    1);
`else
    // Halfword write at 0x2 is refused with a two-cycle ERROR
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h2); #2;
    check("herr_addr_en", ram_en, 0);
    next_cycle(); bus.HWDATA = 32'h12345678; idle(); #2;
    check("herr1_rdy",  bus.HREADYOUT, 0);
    check("herr1_resp", bus.HRESP,     1);
    check("herr1_en",   ram_en,        0);
    next_cycle(); #2;
    check("herr2_rdy",  bus.HREADYOUT, 1);
    check("herr2_resp", bus.HRESP,     1);
    check("herr2_en",   ram_en,        0);
    next_cycle(); #2;
    check("herr_done",  bus.HRESP, 0);
    check("herr_mem",   mem[0],    32'h11111111);
`endif

    // HSIZE = 3 read: ERROR, RAM untouched
    next_cycle(); drive(1, HTRANS_NONSEQ, 0, 3'd3, 32'h4); #2;
    check("serr_addr_en", ram_en, 0);
    next_cycle(); idle(); #2;
    check("serr1_rdy",  bus.HREADYOUT, 0);
    check("serr1_resp", bus.HRESP,     1);
    next_cycle(); #2;
    check("serr2_rdy",  bus.HREADYOUT, 1);
    check("serr2_resp", bus.HRESP,     1);
    next_cycle(); #2;
    check("serr_done",  bus.HRESP, 0);

    // Word write followed by idle goes straight to RAM in its data phase
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h14);
    next_cycle(); bus.HWDATA = 32'h77777777; idle(); #2;
    check("wdir_we",   ram_we,   1);
    check("wdir_addr", ram_addr, 5);
    check("wdir_di",   ram_di,   32'h77777777);

    // Reset while a buffered write to 0xC is pending discards it
    next_cycle(); drive(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'hC);
    next_cycle(); bus.HWDATA = 32'h99999999; drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4);
    next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h4); #2;
    check("mrst_pre_data", bus.HRDATA, 32'h44444444);
    check("mrst_pre_we",   ram_we,     0);
    #1; HRESETn = 1'b0; idle(); #1;
    check("mrst_rdy",  bus.HREADYOUT, 1);
    check("mrst_resp", bus.HRESP,     0);
    check("mrst_en",   ram_en,        0);
    check("mrst_we",   ram_we,        0);
    check("mrst_data", bus.HRDATA,    0);
    next_cycle(); HRESETn = 1'b1;
    next_cycle(); drive(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'hC); #2;
    check("mrst_rd_en",   ram_en,   1);
    check("mrst_rd_addr", ram_addr, 3);
    check("mrst_rd_we",   ram_we,   0);
    next_cycle(); idle(); #2;
    check("mrst_old_data", bus.HRDATA, 32'h33333333);
    check("mrst_mem",      mem[3],     32'h33333333);

    next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
